// File: rtl/sha256_stream_core_if.sv
// Block-input and digest-output handshakes of the SHA-256 stream core.
// The master side is the block source / digest sink, the slave side is the core.
interface sha256_stream_core_if;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_block;
   logic         in_first;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] digest;

   modport master (
      output in_valid, in_block, in_first, in_last, out_ready,
      input  in_ready, out_valid, digest
   );

   modport slave (
      input  in_valid, in_block, in_first, in_last, out_ready,
      output in_ready, out_valid, digest
   );
endinterface

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 compression engine: chains hash state across pre-padded
// 512-bit blocks and runs 1, 2 or 4 rounds per cycle over a rolling schedule.
module sha256_stream_core #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int COUNT_W          = 16
) (
   input  logic               clk,
   input  logic               reset,
   sha256_stream_core_if.slave bus,
   output logic               busy,
   output logic [COUNT_W-1:0] msg_count
);

   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rounds
      $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam int         R      = ROUNDS_PER_CYCLE;
   localparam logic [6:0] R_STEP = 7'(ROUNDS_PER_CYCLE);

   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {IDLE, COMPUTE, FINAL, OUTPUT} state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t             state;
   logic [31:0]        h [8];
   logic [31:0]        v [8];
   logic [31:0]        w [16];
   logic [6:0]         rnd;
   logic               last_r;
   logic               out_valid_r;
   logic [255:0]       digest_r;

   logic [31:0]        blk_words [16];
   logic [31:0]        cv [8];
   logic [31:0]        h_sum [8];
   logic [31:0]        s_next [8];
   logic [31:0]        ext [16 + R];
   logic [31:0]        w_next [16];
   logic [31:0]        t1;
   logic [31:0]        t2;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.digest    = digest_r;
   assign busy          = (state != IDLE);

   // Round datapath: R chained rounds plus R new schedule words per cycle;
   // later schedule words of the same cycle feed on the earlier ones via ext.
   always_comb begin
      t1 = '0;
      t2 = '0;
      for (int i = 0; i < 16; i++) begin
         blk_words[i] = bus.in_block[511 - 32*i -: 32];
      end
      for (int i = 0; i < 8; i++) begin
         cv[i]     = bus.in_first ? IV[i] : h[i];
         h_sum[i]  = h[i] + v[i];
         s_next[i] = v[i];
      end
      for (int i = 0; i < 16 + R; i++) begin
         ext[i] = (i < 16) ? w[i] : 32'h0;
      end
      for (int j = 0; j < R; j++) begin
         t1 = s_next[7] + big_sigma1(s_next[4])
            + ((s_next[4] & s_next[5]) ^ (~s_next[4] & s_next[6]))
            + K[rnd[5:0] + 6'(j)] + ext[j];
         t2 = big_sigma0(s_next[0])
            + ((s_next[0] & s_next[1]) ^ (s_next[0] & s_next[2]) ^ (s_next[1] & s_next[2]));
         s_next[7] = s_next[6];
         s_next[6] = s_next[5];
         s_next[5] = s_next[4];
         s_next[4] = s_next[3] + t1;
         s_next[3] = s_next[2];
         s_next[2] = s_next[1];
         s_next[1] = s_next[0];
         s_next[0] = t1 + t2;
      end
      for (int j = 0; j < R; j++) begin
         ext[16 + j] = small_sigma1(ext[14 + j]) + ext[9 + j]
                     + small_sigma0(ext[1 + j]) + ext[j];
      end
      for (int i = 0; i < 16; i++) begin
         w_next[i] = ext[i + R];
      end
   end

   // Control FSM; a block's chaining value is loaded into both H and the
   // working variables on accept so FINAL can fold them back together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         h           <= IV;
         v           <= '{default: 32'h0};
         w           <= '{default: 32'h0};
         rnd         <= '0;
         last_r      <= 1'b0;
         out_valid_r <= 1'b0;
         digest_r    <= '0;
         msg_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  w      <= blk_words;
                  v      <= cv;
                  h      <= cv;
                  last_r <= bus.in_last;
                  rnd    <= '0;
                  state  <= COMPUTE;
               end
            end
            COMPUTE: begin
               // rnd parks at 64 for one cycle before FINAL
               if (rnd == 7'd64) begin
                  state <= FINAL;
               end else begin
                  v   <= s_next;
                  w   <= w_next;
                  rnd <= rnd + R_STEP;
               end
            end
            FINAL: begin
               h <= h_sum;
               if (last_r) begin
                  digest_r    <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                                  h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
                  out_valid_r <= 1'b1;
                  state       <= OUTPUT;
               end else begin
                  state <= IDLE;
               end
            end
            OUTPUT: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  msg_count   <= msg_count + COUNT_W'(1);
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
